// File: rtl/bus_arbiter_rr_bcast.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_bcast
//
// Shared packet bus arbiter. It takes packets from DRVRS first-word-fall-
// through FIFOs in round-robin order and delivers each one to a single
// device or, for BCAST_ID, to every device except the source. Delivery is
// all-or-nothing: the packet waits in HOLD until every target has room.
// Packets addressed to an ID that is neither a device nor BCAST_ID are
// dropped and counted in a saturating counter.
//
// Ports
//   clk       in   bus clock, rising edge
//   reset     in   asynchronous, active-high reset
//   pndng     in   [DRVRS]          FIFO i non-empty
//   D_pop     in   [DRVRS*PCKG_SZ]  FIFO i head word at [i*PCKG_SZ +: PCKG_SZ]
//   pop       out  [DRVRS]          one-hot, one-cycle pop strobe
//   full      in   [DRVRS]          device i cannot accept a packet
//   push      out  [DRVRS]          one-cycle push mask
//   D_push    out  [PCKG_SZ]        packet shared by all receivers
//   grant_id  out  [$clog2(DRVRS)]  source of the packet in flight
//   busy      out                   high whenever the FSM is not in IDLE
//   drop_cnt  out  [16]             saturating count of dropped packets
// ---------------------------------------------------------------------------
module bus_arbiter_rr_bcast #(
  parameter int              PCKG_SZ  = 24,
  parameter int              DRVRS    = 16,
  parameter int              ID_W     = 8,
  parameter logic [ID_W-1:0] BCAST_ID = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]           pop,
  input  logic [DRVRS-1:0]           full,
  output logic [DRVRS-1:0]           push,
  output logic [PCKG_SZ-1:0]         D_push,
  output logic [$clog2(DRVRS)-1:0]   grant_id,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  localparam int GW = $clog2(DRVRS);
  localparam logic [DRVRS-1:0] ONE_HOT0 = {{(DRVRS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2,
    PUSH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [PCKG_SZ-1:0] pkt_q, pkt_d;
  logic [DRVRS-1:0]   mask_q, mask_d;
  logic [DRVRS-1:0]   pop_q, pop_d;
  logic [DRVRS-1:0]   push_q, push_d;
  logic [PCKG_SZ-1:0] dpush_q, dpush_d;
  logic               busy_q, busy_d;
  logic [15:0]        drop_q, drop_d;

  logic               found_s;
  logic [GW-1:0]      sel_s;
  logic [PCKG_SZ-1:0] head_s;
  logic [ID_W-1:0]    dest_s;
  logic [DRVRS-1:0]   mask_s;
  logic               dest_ok_s;
  logic [GW-1:0]      ptr_next_s;

  // Round-robin search: first pending FIFO at or above rr_ptr, wrapping.
  always_comb begin
    int idx_v;
    found_s = 1'b0;
    sel_s   = '0;
    idx_v   = 0;
    for (int j = 0; j < DRVRS; j++) begin
      idx_v = (int'(rr_ptr_q) + j) % DRVRS;
      if (!found_s && pndng[idx_v]) begin
        found_s = 1'b1;
        sel_s   = GW'(idx_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Head word of the granted FIFO and its delivery mask.
  always_comb begin
    head_s = D_pop[grant_q*PCKG_SZ +: PCKG_SZ];
    dest_s = head_s[PCKG_SZ-1 -: ID_W];
    if (dest_s == BCAST_ID) begin
      mask_s    = ~(ONE_HOT0 << grant_q);
      dest_ok_s = 1'b1;
    end else if (32'(dest_s) < 32'(DRVRS)) begin
      // A self-addressed packet goes back to its own source.
      mask_s    = ONE_HOT0 << dest_s;
      dest_ok_s = 1'b1;
    end else begin
      mask_s    = '0;
      dest_ok_s = 1'b0;
    end
  end

  // Pointer value after the current grant completes.
  always_comb begin
    if (grant_q == GW'(DRVRS-1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_q + GW'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    pkt_d    = pkt_q;
    mask_d   = mask_q;
    pop_d    = '0;
    push_d   = '0;
    dpush_d  = dpush_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          grant_d = sel_s;
          pop_d   = ONE_HOT0 << sel_s;
          state_d = POP;
        end else begin
          state_d = IDLE;
        end
      end
      POP: begin
        pkt_d  = head_s;
        mask_d = mask_s;
        if (!dest_ok_s) begin
          drop_d   = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          rr_ptr_d = ptr_next_s;
          state_d  = IDLE;
        end else if ((full & mask_s) == '0) begin
          push_d  = mask_s;
          dpush_d = head_s;
          state_d = PUSH;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if ((full & mask_q) == '0) begin
          push_d  = mask_q;
          dpush_d = pkt_q;
          state_d = PUSH;
        end else begin
          state_d = HOLD;
        end
      end
      PUSH: begin
        rr_ptr_d = ptr_next_s;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      pkt_q    <= '0;
      mask_q   <= '0;
      pop_q    <= '0;
      push_q   <= '0;
      dpush_q  <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      pkt_q    <= pkt_d;
      mask_q   <= mask_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      dpush_q  <= dpush_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = dpush_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_arbiter_rr_bcast.sv
module tb_bus_arbiter_rr_bcast;

  localparam int PS = 24;
  localparam int N  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    pndng;
  logic [N*PS-1:0] D_pop;
  logic [N-1:0]    pop;
  logic [N-1:0]    full;
  logic [N-1:0]    push;
  logic [PS-1:0]   D_push;
  logic [3:0]      grant_id;
  logic            busy;
  logic [15:0]     drop_cnt;

  typedef struct {
    logic [N-1:0]  mask;
    logic [PS-1:0] data;
    logic [3:0]    src;
  } exp_t;

  logic [PS-1:0] fifo_q [N][$];
  exp_t          sb_q[$];
  logic [N-1:0]  last_pop;
  int            checks;
  int            errors;
  bit            done;

  bus_arbiter_rr_bcast #(.PCKG_SZ(PS), .DRVRS(N), .ID_W(8), .BCAST_ID(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .full(full), .push(push), .D_push(D_push), .grant_id(grant_id),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void drive_fifos();
    for (int i = 0; i < N; i++) begin
      if (fifo_q[i].size() != 0) begin
        pndng[i] = 1'b1;
        D_pop[i*PS +: PS] = fifo_q[i][0];
      end else begin
        pndng[i] = 1'b0;
        D_pop[i*PS +: PS] = '0;
      end
    end
  endfunction

  function automatic bit fifos_busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < N; i++) if (fifo_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Advance one cycle; the FIFO model retires the head that the DUT
  // latched at the edge closing the previous pop cycle.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (last_pop[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
    last_pop = pop;
    #1;
    drive_fifos();
  endtask

  task automatic load(input int dev, input logic [PS-1:0] word);
    fifo_q[dev].push_back(word);
    drive_fifos();
  endtask

  task automatic expect_push(input logic [N-1:0] mask, input logic [PS-1:0] data, input int src);
    exp_t e;
    e.mask = mask;
    e.data = data;
    e.src  = 4'(src);
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || fifos_busy() || sb_q.size() != 0) && n < budget);
    checks++;
    if (busy || fifos_busy() || sb_q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles (busy=%0b pending_exp=%0d)", n, busy, sb_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done     = 1'b0;
    last_pop = '0;
    reset    = 1'b1;
    full     = '0;
    pndng    = '0;
    D_pop    = '0;
    fork
      begin : stim
        repeat (3) tick();
        reset = 1'b0;

        // Reset values
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_dpush", D_push, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);

        // Single unicast with exact cycle timing
        load(3, 24'h05ABCD);
        expect_push(16'h0020, 24'h05ABCD, 3);
        tick();
        chk("uni_pop", pop, 32'h0008);
        chk("uni_busy1", busy, 1);
        chk("uni_grant", grant_id, 3);
        tick();
        chk("uni_push", push, 32'h0020);
        chk("uni_pop_off", pop, 0);
        chk("uni_busy2", busy, 1);
        tick();
        chk("uni_idle", busy, 0);
        chk("uni_push_off", push, 0);
        chk("uni_dpush_hold", D_push, 32'h05ABCD);
        wait_idle(20);

        // Broadcast from device 7
        load(7, 24'hFF1234);
        expect_push(16'hFF7F, 24'hFF1234, 7);
        wait_idle(20);

        // Unicast back-pressure: full[9] for 10 cycles
        full[9] = 1'b1;
        load(2, 24'h09BEEF);
        expect_push(16'h0200, 24'h09BEEF, 2);
        tick();
        chk("bp_pop", pop, 32'h0004);
        for (int k = 0; k < 10; k++) begin
          tick();
          chk("bp_hold_push", push, 0);
          chk("bp_hold_busy", busy, 1);
        end
        full[9] = 1'b0;
        tick();
        chk("bp_release_push", push, 32'h0200);
        wait_idle(20);

        // Broadcast back-pressure: one target full; source full is ignored
        full[12] = 1'b1;
        full[4]  = 1'b1;
        load(4, 24'hFF5A5A);
        expect_push(16'hFFEF, 24'hFF5A5A, 4);
        tick();
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("bbp_hold_push", push, 0);
        end
        full[12] = 1'b0;
        tick();
        chk("bbp_release_push", push, 32'hFFEF);
        full = '0;
        wait_idle(20);

        // Self-address and highest valid ID; rr_ptr=5 so device 6 goes first
        load(6, 24'h06C0DE);
        load(1, 24'h0F0001);
        expect_push(16'h0040, 24'h06C0DE, 6);
        expect_push(16'h8000, 24'h0F0001, 1);
        wait_idle(40);

        // Invalid IDs: 0x20, then DRVRS itself (0x10)
        load(5, 24'h20FFFF);
        tick();
        chk("drop_pop", pop, 32'h0020);
        wait_idle(20);
        chk("drop_cnt1", drop_cnt, 1);
        chk("drop_dpush_hold", D_push, 32'h0F0001);
        load(0, 24'h100000);
        wait_idle(20);
        chk("drop_cnt2", drop_cnt, 2);

        // Saturation
        force dut.drop_q = 16'hFFFF;
        tick();
        release dut.drop_q;
        tick();
        chk("sat_preset", drop_cnt, 32'hFFFF);
        load(3, 24'h20AAAA);
        wait_idle(20);
        chk("sat_hold", drop_cnt, 32'hFFFF);

        // Reset during HOLD (rr_ptr is 4 beforehand)
        full[10] = 1'b1;
        load(9, 24'h0A7777);
        repeat (3) tick();
        chk("rst_mid_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_pop", pop, 0);
        chk("rst_mid_push", push, 0);
        chk("rst_mid_dpush", D_push, 0);
        chk("rst_mid_grant", grant_id, 0);
        chk("rst_mid_busy0", busy, 0);
        chk("rst_mid_drop", drop_cnt, 0);
        sb_q.delete();
        tick();
        reset = 1'b0;
        full  = '0;
        load(8, 24'h0C0808);
        load(0, 24'h030101);
        expect_push(16'h0008, 24'h030101, 0);
        expect_push(16'h1000, 24'h0C0808, 8);
        wait_idle(40);

        // Fairness: all FIFOs hold two packets
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
          for (int i = 0; i < N; i++) begin
            logic [PS-1:0] w;
            w = {8'((i + 1) % N), 8'(i), 8'(r)};
            fifo_q[i].push_back(w);
            expect_push(16'h0001 << ((i + 1) % N), w, i);
          end
        end
        drive_fifos();
        wait_idle(300);
        chk("fair_drop", drop_cnt, 0);

        done = 1'b1;
      end
      begin : monitor
        while (!done) begin
          @(negedge clk);
          if (!reset && push != '0) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_push: got push=%0h with no packet expected", push);
            end else begin
              exp_t e;
              e = sb_q.pop_front();
              chk("sb_push_mask", push, e.mask);
              chk("sb_d_push", D_push, e.data);
              chk("sb_grant_src", grant_id, e.src);
            end
          end
        end
      end
    join
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
